// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative unsigned multiply / divide, one result bit per cycle.
// Result, destination index and write strobe feed the register file write port.
// Optional feature macro: MULT_DIV_DIVIDER_EN (defined = restoring divider present;
// undefined = divide ops finish after one cycle with result 0 and no write).
// Handshake: start_i is sampled only in IDLE; busy_o is high while an op is in
// flight; done_o (and wr_en_o for supported ops) pulse for one cycle; result_o
// and dest_reg_o hold until the next accepted start.
module mult_div_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] operand_a_i,
    input  logic [N-1:0] operand_b_i,
    input  logic [4:0]   dest_reg_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] result_o,
    output logic [4:0]   dest_reg_o,
    output logic         wr_en_o,
    output logic [1:0]   state_o
);

`ifdef MULT_DIV_DIVIDER_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    // Counter has one extra sign bit: it runs N-1 .. 0, and the wrap to
    // negative marks the final cycle that publishes the result.
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef MULT_DIV_DIVIDER_EN
        ST_DIV  = 2'd2,
`endif
        ST_DONE = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   hi, lo, b_r;     // hi/lo double as rem/quo in divide
    logic [1:0]     op_r;
    logic [CW-1:0]  cnt;
    logic           accept, cnt_done;
    logic [N:0]     mul_sum;
    logic [N-1:0]   result_sel;

    assign accept   = (state == ST_IDLE) && start_i;
    assign cnt_done = cnt[CW-1];
    assign mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);

`ifdef MULT_DIV_DIVIDER_EN
    // rem < divisor always holds, so the shifted value is below 2*divisor and
    // bit N of the N+1-bit difference is exactly the borrow of the trial subtract.
    logic [N:0] div_shift, div_diff;
    logic       div_ge;
    assign div_shift = {hi, lo[N-1]};
    assign div_diff  = div_shift - {1'b0, b_r};
    assign div_ge    = ~div_diff[N];
`endif

    assign busy_o  = (state != ST_IDLE) && (state != ST_DONE);
    assign done_o  = (state == ST_DONE);
    assign wr_en_o = done_o && (!op_r[1] || DIV_EN);
    assign state_o = state;

    // Pick the result half for the latched op; unsupported divide yields 0.
    always_comb begin
        result_sel = '0;
        if (!op_r[1] || DIV_EN) begin
            result_sel = op_r[0] ? hi : lo;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic: IDLE -> MUL/DIV on start, run until the counter wraps, DONE for one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
`ifdef MULT_DIV_DIVIDER_EN
                    state_nxt = op_i[1] ? ST_DIV : ST_MUL;
`else
                    state_nxt = ST_MUL;
`endif
                end
            end
            ST_MUL:  if (cnt_done) state_nxt = ST_DONE;
`ifdef MULT_DIV_DIVIDER_EN
            ST_DIV:  if (cnt_done) state_nxt = ST_DONE;
`endif
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, one shift-add / restoring-divide step per cycle, result publish.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi         <= '0;
            lo         <= '0;
            b_r        <= '0;
            op_r       <= '0;
            cnt        <= '0;
            result_o   <= '0;
            dest_reg_o <= '0;
        end else if (accept) begin
            hi         <= '0;
            lo         <= operand_a_i;
            b_r        <= operand_b_i;
            op_r       <= op_i;
            dest_reg_o <= dest_reg_i;
            // Without the divider a divide op skips straight to the publish cycle.
            cnt        <= (op_i[1] && !DIV_EN) ? '1 : CNT_INIT;
        end else if (state == ST_MUL && !cnt_done) begin
            hi  <= mul_sum[N:1];
            lo  <= {mul_sum[0], lo[N-1:1]};
            cnt <= cnt - CNT_ONE;
`ifdef MULT_DIV_DIVIDER_EN
        end else if (state == ST_DIV && !cnt_done) begin
            hi  <= div_ge ? div_diff[N-1:0] : div_shift[N-1:0];
            lo  <= {lo[N-2:0], div_ge};
            cnt <= cnt - CNT_ONE;
`endif
        end else if (busy_o && cnt_done) begin
            result_o <= result_sel;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table, hand-written corner sequences and random ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;

    localparam int N = 32;
`ifdef MULT_DIV_DIVIDER_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start_i;
    logic [1:0]   op_i;
    logic [N-1:0] operand_a_i, operand_b_i;
    logic [4:0]   dest_reg_i;
    logic         busy_o, done_o, wr_en_o;
    logic [N-1:0] result_o;
    logic [4:0]   dest_reg_o;
    logic [1:0]   state_dbg;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [N-1:0] exp_q[$];

    typedef struct {
        logic [1:0]   op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [4:0]   dest;
        logic [N-1:0] exp_res;
        logic         exp_wr;
    } vec_t;
    vec_t vecs [10];

    mult_div_unit #(.N(N)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .dest_reg_i(dest_reg_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .dest_reg_o(dest_reg_o), .wr_en_o(wr_en_o), .state_o(state_dbg)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: plain arithmetic on the operands.
    function automatic logic [N-1:0] ref_model(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [2*N-1:0] prod;
        prod = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        if (op == 2'd0) return prod[N-1:0];
        if (op == 2'd1) return prod[2*N-1:N];
        if (!DIV_EN)    return '0;
        if (op == 2'd2) return (b == 0) ? {N{1'b1}} : a / b;
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int ref_latency(input logic [1:0] op);
        return (op[1] && !DIV_EN) ? 1 : N + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Driver: present a request, let one edge accept it, then scramble the inputs.
    task automatic start_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b, input logic [4:0] dest);
        start_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b; dest_reg_i = dest;
        @(posedge clk); #1;
        start_i = 1'b0;
        operand_a_i = $urandom; operand_b_i = $urandom; dest_reg_i = 5'($urandom_range(0, 31));
    endtask

    // Count edges from the accepting edge until done_o; lat = -1 on timeout.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = -1;
        busy_cnt = int'(busy_o);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done_o) begin
                lat = k;
                break;
            end
            busy_cnt += int'(busy_o);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [4:0] dest, input logic [N-1:0] exp_res, input logic exp_wr,
                          input int exp_lat, input string tag);
        int lat, busy_cnt;
        logic [N-1:0] exp_v;
        exp_q.push_back(exp_res);
        start_op(op, a, b, dest);
        wait_done(lat, busy_cnt);
        exp_v = exp_q.pop_front();
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        if (lat > 0) begin
            check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
            check({tag, " result"}, 64'(result_o), 64'(exp_v));
            check({tag, " dest"}, 64'(dest_reg_o), 64'(dest));
            check({tag, " wr_en"}, 64'(wr_en_o), 64'(exp_wr));
            @(posedge clk); #1;
            check({tag, " done_pulse_width"}, 64'({done_o, wr_en_o}), 64'(0));
            check({tag, " result_hold"}, 64'(result_o), 64'(exp_v));
        end
    endtask

    initial begin
        int lat, busy_cnt, done_seen;
        logic [1:0]   r_op;
        logic [N-1:0] r_a, r_b;

        vecs[0] = '{2'd0, 32'hFFFF_FFFF, 32'h2, 5'd5,  32'hFFFF_FFFE, 1'b1};
        vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'h2, 5'd5,  32'h0000_0001, 1'b1};
        vecs[2] = '{2'd2, 32'd100,       32'd7, 5'd9,  DIV_EN ? 32'd14 : 32'd0, DIV_EN};
        vecs[3] = '{2'd3, 32'd100,       32'd7, 5'd9,  DIV_EN ? 32'd2  : 32'd0, DIV_EN};
        vecs[4] = '{2'd2, 32'h1234_5678, 32'h0, 5'd10, DIV_EN ? 32'hFFFF_FFFF : 32'd0, DIV_EN};
        vecs[5] = '{2'd3, 32'h1234_5678, 32'h0, 5'd10, DIV_EN ? 32'h1234_5678 : 32'd0, DIV_EN};
        vecs[6] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'hFFFF_FFFE, 1'b1};
        vecs[7] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b1};
        vecs[8] = '{2'd2, 32'd7,         32'd100, 5'd1, 32'd0, DIV_EN};
        vecs[9] = '{2'd3, 32'd7,         32'd100, 5'd1, DIV_EN ? 32'd7 : 32'd0, DIV_EN};

        // Reset phase
        reset = 1'b0; start_i = 1'b0; op_i = '0; operand_a_i = '0; operand_b_i = '0; dest_reg_i = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", 64'({busy_o, done_o, wr_en_o, dest_reg_o}), 64'(0));
        check("reset result", 64'(result_o), 64'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        check("idle after reset", 64'({busy_o, done_o, wr_en_o}), 64'(0));

        // Vector table
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].exp_res,
                   vecs[i].exp_wr, ref_latency(vecs[i].op), $sformatf("vec%0d", i));
        end

        // Reset in the middle of a multiply discards it
        start_op(2'd0, 32'd7, 32'd9, 5'd3);
        repeat (4) begin @(posedge clk); #1; end
        check("busy before mid reset", 64'(busy_o), 64'(1));
        reset = 1'b0;
        #1;
        check("mid reset ctrl", 64'({busy_o, done_o, wr_en_o}), 64'(0));
        check("mid reset dest", 64'(dest_reg_o), 64'(0));
        check("mid reset result", 64'(result_o), 64'(0));
        @(posedge clk); #1;
        reset = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            done_seen += int'(done_o | wr_en_o | busy_o);
        end
        check("no done after mid reset", 64'(done_seen), 64'(0));
        run_op(2'd0, 32'd7, 32'd9, 5'd4, 32'd63, 1'b1, N + 1, "after_reset");

        // Start held high while busy and through the done cycle
        start_op(2'd0, 32'd123, 32'd456, 5'd7);
        start_i = 1'b1; op_i = 2'd1; operand_a_i = 32'hDEAD_BEEF; operand_b_i = 32'h1234_5678; dest_reg_i = 5'd12;
        wait_done(lat, busy_cnt);
        check("busy_start latency", 64'(lat), 64'(N + 1));
        check("busy_start result", 64'(result_o), 64'(ref_model(2'd0, 32'd123, 32'd456)));
        check("busy_start dest", 64'(dest_reg_o), 64'(7));
        @(posedge clk); #1;
        check("start in done ignored", 64'({busy_o, done_o}), 64'(0));
        check("start in done result hold", 64'(result_o), 64'(32'd56088));
        @(posedge clk); #1;
        check("start after done accepted", 64'(busy_o), 64'(1));
        start_i = 1'b0;
        wait_done(lat, busy_cnt);
        check("second op latency", 64'(lat), 64'(N + 1));
        check("second op result", 64'(result_o), 64'(ref_model(2'd1, 32'hDEAD_BEEF, 32'h1234_5678)));
        check("second op dest", 64'(dest_reg_o), 64'(12));
        @(posedge clk); #1;

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = ($urandom_range(0, 4) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
            r_b  = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 15)) : N'($urandom);
            run_op(r_op, r_a, r_b, 5'($urandom_range(0, 31)), ref_model(r_op, r_a, r_b),
                   !r_op[1] || DIV_EN, ref_latency(r_op), $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
